// File: rtl/pgm_ddram_pkg.sv
// Shared constants and types for the PGM DDRAM arbiter.
package pgm_ddram_pkg;

    localparam int NREQ_DEF = 4;
    localparam int AW_DEF   = 29;

    // Requester port indices; port 0 is the strict-priority port.
    localparam int PORT_DL  = 0;
    localparam int PORT_VID = 1;
    localparam int PORT_CPU = 2;
    localparam int PORT_SND = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } arb_state_t;

endpackage

// File: rtl/pgm_rr_picker.sv
// Rotate-priority encoder for the round-robin ports 1..NREQ-1.
// The search starts at the port after rr_last and wraps from NREQ-1 back to 1.
module pgm_rr_picker
    import pgm_ddram_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:1] valid,
    input  logic [IW-1:0]   rr_last,
    output logic [NREQ-1:1] grant,
    output logic [IW-1:0]   grant_idx
);

    // Walk the ports in rotated order and keep the first valid one.
    always_comb begin
        logic [IW-1:0] cand;
        logic          found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 1; k < NREQ; k++) begin
            cand = IW'(((int'(rr_last) - 1 + k) % (NREQ - 1)) + 1);
            if (!found && valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/pgm_ddram_arbiter.sv
// Single-port DDRAM arbiter for the PGM core.
// Handshake: a requester raises req_valid with stable fields and holds it until
// the one-cycle req_ack pulse, which marks the cycle after DDRAM accepted the
// command (strobe high, busy low at a clock edge). Read data returns later on
// the shared rd_data bus qualified by a one-cycle rd_valid pulse for the owner.
// Only one command is outstanding at a time; arbitration happens in IDLE only.
module pgm_ddram_arbiter
    import pgm_ddram_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int AW      = AW_DEF,
    parameter int TIMEOUT = 1023
) (
    input  logic                    fixed_50m_clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ-1:0]         req_we,
    input  logic [NREQ-1:0][AW-1:0] req_addr,
    input  logic [NREQ-1:0][63:0]   req_din,
    input  logic [NREQ-1:0][7:0]    req_be,
    output logic [NREQ-1:0]         req_ack,
    output logic [63:0]             rd_data,
    output logic [NREQ-1:0]         rd_valid,
    output logic                    rd_err,
    output logic                    ddram_rd,
    output logic                    ddram_we,
    output logic [AW-1:0]           ddram_addr,
    output logic [63:0]             ddram_din,
    output logic [7:0]              ddram_be,
    output logic [3:0]              ddram_burstcnt,
    input  logic                    ddram_busy,
    input  logic [63:0]             ddram_dout,
    input  logic                    ddram_dout_ready,
    output logic [1:0]              dbg_state
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_t        state_q, state_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     rr_last_q, rr_last_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              rd_q, rd_d, we_q, we_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [63:0]       din_q, din_d;
    logic [7:0]        be_q, be_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [NREQ-1:0]   rv_q, rv_d;
    logic              err_q, err_d;
    logic [63:0]       rdata_q, rdata_d;

    logic [NREQ-1:0]   elig;
    logic [NREQ-1:1]   rr_grant;
    logic [IW-1:0]     rr_idx;
    logic [IW-1:0]     win;

    // A port whose ack is on the wire this cycle is still holding req_valid for
    // the request just accepted, so it is kept out of this arbitration round.
    assign elig = req_valid & ~ack_q;
    assign win  = elig[PORT_DL] ? IW'(PORT_DL) : rr_idx;

    pgm_rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .valid     (elig[NREQ-1:1]),
        .rr_last   (rr_last_q),
        .grant     (rr_grant),
        .grant_idx (rr_idx)
    );

    // Next-state, command fields, pulses and the read timeout counter.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        we_d      = we_q;
        addr_d    = addr_q;
        din_d     = din_q;
        be_d      = be_q;
        ack_d     = '0;
        rv_d      = '0;
        err_d     = 1'b0;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (elig[PORT_DL] || (|rr_grant)) begin
                    owner_d = win;
                    if (!elig[PORT_DL]) begin
                        rr_last_d = rr_idx;
                    end
                    addr_d  = req_addr[win];
                    din_d   = req_din[win];
                    be_d    = req_be[win];
                    we_d    = req_we[win];
                    rd_d    = ~req_we[win];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!ddram_busy) begin
                    rd_d           = 1'b0;
                    we_d           = 1'b0;
                    ack_d[owner_q] = 1'b1;
                    cnt_d          = '0;
                    state_d        = we_q ? IDLE : WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (ddram_dout_ready) begin
                    rdata_d       = ddram_dout;
                    rv_d[owner_q] = 1'b1;
                    state_d       = IDLE;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    rdata_d       = '0;
                    rv_d[owner_q] = 1'b1;
                    err_d         = 1'b1;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge fixed_50m_clk) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            rr_last_q <= IW'(NREQ - 1);
            cnt_q     <= '0;
            rd_q      <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
            be_q      <= '0;
            ack_q     <= '0;
            rv_q      <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            be_q      <= be_d;
            ack_q     <= ack_d;
            rv_q      <= rv_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    assign req_ack        = ack_q;
    assign rd_valid       = rv_q;
    assign rd_err         = err_q;
    assign rd_data        = rdata_q;
    assign ddram_rd       = rd_q;
    assign ddram_we       = we_q;
    assign ddram_addr     = addr_q;
    assign ddram_din      = din_q;
    assign ddram_be       = be_q;
    assign ddram_burstcnt = 4'd1;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_pgm_ddram_arbiter.sv
// Bench for pgm_ddram_arbiter: directed scenarios plus a randomized run, all
// checked every cycle against a transaction-level model of the arbiter.
module tb_pgm_ddram_arbiter;
    import pgm_ddram_pkg::*;

    localparam int NREQ = 4;
    localparam int AW   = 29;
    localparam int TMO  = 7;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [63:0]   din;
        logic [7:0]    be;
    } req_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NREQ-1:0]         req_valid, req_we, req_ack, rd_valid;
    logic [NREQ-1:0][AW-1:0] req_addr;
    logic [NREQ-1:0][63:0]   req_din;
    logic [NREQ-1:0][7:0]    req_be;
    logic [63:0]             rd_data, ddram_din, ddram_dout;
    logic                    rd_err, ddram_rd, ddram_we, ddram_busy, ddram_dout_ready;
    logic [AW-1:0]           ddram_addr;
    logic [7:0]              ddram_be;
    logic [3:0]              ddram_burstcnt;
    logic [1:0]              dbg_state;

    int          n_cmp = 0;
    int          n_bad = 0;
    req_t        rq[NREQ][$];
    logic        auto_mode, t_busy, t_rdy, track;
    logic [63:0] t_dout;
    logic [1:0]  exp_q[$];
    logic [NREQ-1:0] ack_seen, last_valid;

    // model state: expected registered outputs plus the command being tracked
    logic [NREQ-1:0] m_ack, m_rv;
    logic            m_err, m_rd, m_we;
    logic [AW-1:0]   m_addr;
    logic [63:0]     m_din, m_data;
    logic [7:0]      m_be;
    int              m_owner, m_rr, m_age;
    bit              m_read_open;

    pgm_ddram_arbiter #(.NREQ(NREQ), .AW(AW), .TIMEOUT(TMO)) dut (
        .fixed_50m_clk    (clk),
        .reset            (rst),
        .req_valid        (req_valid),
        .req_we           (req_we),
        .req_addr         (req_addr),
        .req_din          (req_din),
        .req_be           (req_be),
        .req_ack          (req_ack),
        .rd_data          (rd_data),
        .rd_valid         (rd_valid),
        .rd_err           (rd_err),
        .ddram_rd         (ddram_rd),
        .ddram_we         (ddram_we),
        .ddram_addr       (ddram_addr),
        .ddram_din        (ddram_din),
        .ddram_be         (ddram_be),
        .ddram_burstcnt   (ddram_burstcnt),
        .ddram_busy       (ddram_busy),
        .ddram_dout       (ddram_dout),
        .ddram_dout_ready (ddram_dout_ready),
        .dbg_state        (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: evaluated at each rising edge from the inputs seen there.
    initial begin
        logic [NREQ-1:0] elig, prev_ack;
        int win, p;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_ack = '0; m_rv = '0; m_err = 1'b0; m_rd = 1'b0; m_we = 1'b0;
                m_addr = '0; m_din = '0; m_be = '0; m_data = '0;
                m_rr = NREQ - 1; m_owner = 0; m_age = 0; m_read_open = 0;
            end else begin
                prev_ack = m_ack;
                m_ack = '0; m_rv = '0; m_err = 1'b0;
                if (m_rd || m_we) begin
                    // command on the pins is taken when DDRAM is not busy
                    if (!ddram_busy) begin
                        m_ack[m_owner] = 1'b1;
                        m_read_open    = m_rd;
                        m_age          = 0;
                        m_rd = 1'b0; m_we = 1'b0;
                    end
                end else if (m_read_open) begin
                    if (ddram_dout_ready) begin
                        m_data = ddram_dout; m_rv[m_owner] = 1'b1; m_read_open = 0;
                    end else if (m_age == TMO) begin
                        m_data = '0; m_rv[m_owner] = 1'b1; m_err = 1'b1; m_read_open = 0;
                    end else begin
                        m_age++;
                    end
                end else begin
                    elig = req_valid & ~prev_ack;
                    win  = -1;
                    if (elig[0]) win = 0;
                    else begin
                        p = m_rr;
                        for (int k = 1; k < NREQ; k++) begin
                            p = (p == NREQ - 1) ? 1 : p + 1;
                            if (win < 0 && elig[p]) win = p;
                        end
                    end
                    if (win >= 0) begin
                        if (win != 0) m_rr = win;
                        m_owner = win;
                        m_we = req_we[win]; m_rd = !req_we[win];
                        m_addr = req_addr[win]; m_din = req_din[win]; m_be = req_be[win];
                    end
                end
            end
        end
    end

    // Compare process: every cycle, at the falling edge.
    initial begin
        logic [1:0] g;
        forever begin
            @(negedge clk);
            check("req_ack", req_ack, m_ack);
            check("rd_valid", rd_valid, m_rv);
            check("rd_err", rd_err, m_err);
            check("ddram_rd", ddram_rd, m_rd);
            check("ddram_we", ddram_we, m_we);
            check("ddram_addr", ddram_addr, m_addr);
            check("ddram_din", ddram_din, m_din);
            check("ddram_be", ddram_be, m_be);
            check("rd_data", rd_data, m_data);
            check("burstcnt", ddram_burstcnt, 64'd1);
            ack_seen = req_ack;
            if (track) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (req_ack[i]) begin
                        if (exp_q.size() == 0) begin
                            n_cmp++; n_bad++;
                            $display("FAIL grant_order: port %0d acked, no grant expected", i);
                        end else begin
                            g = exp_q.pop_front();
                            check("grant_order", 64'(i), 64'(g));
                        end
                    end
                end
            end
        end
    end

    // Requesters must hold req_valid until they have seen req_ack.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst) begin
                for (int i = 0; i < NREQ; i++) begin
                    assert (!(last_valid[i] && !req_valid[i] && !ack_seen[i]))
                        else $error("req_valid[%0d] dropped before req_ack", i);
                end
            end
            last_valid = req_valid;
        end
    end

    task automatic push_req(input int p, input logic we, input logic [AW-1:0] a,
                            input logic [63:0] d, input logic [7:0] be);
        req_t r;
        r.we = we; r.addr = a; r.din = d; r.be = be;
        rq[p].push_back(r);
    endtask

    task automatic push_rand(input int p);
        push_req(p, 1'($urandom_range(0, 1)), AW'($urandom), {$urandom, $urandom}, 8'($urandom));
    endtask

    task automatic flush();
        for (int i = 0; i < NREQ; i++) rq[i].delete();
        req_valid = '0;
    endtask

    // One cycle of stimulus, applied at the falling edge.
    task automatic step();
        req_t r;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ack[i]) req_valid[i] = 1'b0;
            if (!req_valid[i] && rq[i].size() > 0) begin
                r = rq[i].pop_front();
                req_valid[i] = 1'b1; req_we[i] = r.we; req_addr[i] = r.addr;
                req_din[i] = r.din; req_be[i] = r.be;
            end
        end
        if (auto_mode) begin
            ddram_busy       = ($urandom_range(0, 3) == 0);
            ddram_dout_ready = ($urandom_range(0, 2) == 0);
            ddram_dout       = {$urandom, $urandom};
        end else begin
            ddram_busy       = t_busy;
            ddram_dout_ready = t_rdy;
            ddram_dout       = t_dout;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush();
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic wait_ack(input int p);
        int n = 0;
        do begin
            step();
            n++;
        end while (!req_ack[p] && n < 40);
        check("ack_wait", 64'(req_ack[p]), 64'd1);
    endtask

    initial begin
        int acks, cyc;
        rst = 1'b1;
        req_valid = '0; req_we = '0; req_addr = '0; req_din = '0; req_be = '0;
        ddram_busy = 1'b0; ddram_dout_ready = 1'b0; ddram_dout = '0;
        auto_mode = 1'b0; t_busy = 1'b0; t_rdy = 1'b0; t_dout = '0; track = 1'b0;
        ack_seen = '0; last_valid = '0;
        repeat (3) step();
        check("rst_outputs", {req_ack, rd_valid, rd_err, ddram_rd, ddram_we}, 64'd0);
        check("rst_rd_data", rd_data, 64'd0);
        check("rst_burstcnt", ddram_burstcnt, 64'd1);
        check("rst_state", dbg_state, 64'(IDLE));
        rst = 1'b0;

        // port 0 write, DDRAM never busy
        push_req(0, 1'b1, AW'('h100), 64'hDEADBEEF_CAFEF00D, 8'hFF);
        step();
        check("wr_we_before", ddram_we, 64'd0);
        step();
        check("wr_we", ddram_we, 64'd1);
        check("wr_rd", ddram_rd, 64'd0);
        check("wr_addr", ddram_addr, 64'h100);
        check("wr_din", ddram_din, 64'hDEADBEEF_CAFEF00D);
        check("wr_be", ddram_be, 64'hFF);
        check("wr_ack_early", req_ack, 64'd0);
        step();
        check("wr_we_one_cycle", ddram_we, 64'd0);
        check("wr_ack", req_ack, 64'b0001);
        step();
        check("wr_ack_pulse", req_ack, 64'd0);

        // port 2 read stalled by busy for 5 edges; stray dout_ready is ignored
        push_req(2, 1'b0, AW'('h2A0), 64'd0, 8'd0);
        t_busy = 1'b1; t_rdy = 1'b1; t_dout = 64'hBAD0_BAD0_BAD0_BAD0;
        step();
        for (int i = 1; i <= 6; i++) begin
            t_busy = (i <= 5);
            step();
            check("stall_rd", ddram_rd, 64'd1);
            check("stall_addr", ddram_addr, 64'h2A0);
            check("stall_ack", req_ack, 64'd0);
            check("stall_no_rv", rd_valid, 64'd0);
        end
        t_busy = 1'b0; t_rdy = 1'b1; t_dout = 64'h1122334455667788;
        step();
        check("stall_rd_drop", ddram_rd, 64'd0);
        check("stall_ack", req_ack, 64'b0100);
        t_rdy = 1'b0;
        step();
        check("stall_rv", rd_valid, 64'b0100);
        check("stall_data", rd_data, 64'h1122334455667788);
        check("stall_err", rd_err, 64'd0);

        // round robin among 1..3, port 0 pre-empts once, then rotation resumes
        do_reset();
        t_busy = 1'b0; t_rdy = 1'b1; t_dout = 64'h5555_AAAA_5555_AAAA;
        exp_q = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        track = 1'b1;
        for (int p = 1; p < NREQ; p++) begin
            push_req(p, 1'b0, AW'(p * 'h10), 64'd0, 8'd0);
            push_req(p, 1'b0, AW'(p * 'h10 + 1), 64'd0, 8'd0);
        end
        acks = 0; cyc = 0;
        while (acks < 3 && cyc < 200) begin
            step(); cyc++;
            acks += $countones(req_ack);
        end
        push_req(0, 1'b0, AW'('h777), 64'd0, 8'd0);
        while (exp_q.size() > 0 && cyc < 400) begin
            step(); cyc++;
        end
        step();
        check("rr_all_granted", 64'(exp_q.size()), 64'd0);
        track = 1'b0;

        // read timeout on port 3
        t_rdy = 1'b0;
        repeat (3) step();
        push_req(3, 1'b0, AW'('h3C0), 64'd0, 8'd0);
        wait_ack(3);
        for (int i = 1; i <= 7; i++) begin
            step();
            check("tmo_quiet", rd_valid, 64'd0);
        end
        step();
        check("tmo_rv", rd_valid, 64'b1000);
        check("tmo_err", rd_err, 64'd1);
        check("tmo_data", rd_data, 64'd0);
        check("tmo_state", dbg_state, 64'(IDLE));
        step();
        check("tmo_rv_pulse", rd_valid, 64'd0);

        // reset while a read is outstanding, then a stray dout_ready
        push_req(2, 1'b0, AW'('h5A0), 64'd0, 8'd0);
        wait_ack(2);
        step(); step();
        rst = 1'b1;
        flush();
        step();
        check("mid_rst_outputs", {req_ack, rd_valid, rd_err, ddram_rd, ddram_we}, 64'd0);
        check("mid_rst_fields", {ddram_be, ddram_addr}, 64'd0);
        check("mid_rst_data", rd_data, 64'd0);
        rst = 1'b0;
        t_rdy = 1'b1; t_dout = 64'hFEED_FACE_0000_0001;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stray_rv", rd_valid, 64'd0);
        end
        t_rdy = 1'b0;
        push_req(1, 1'b0, AW'('h1A0), 64'd0, 8'd0);
        wait_ack(1);
        t_rdy = 1'b1; t_dout = 64'h0123456789ABCDEF;
        step();
        t_rdy = 1'b0;
        step();
        check("post_rst_rv", rd_valid, 64'b0010);
        check("post_rst_data", rd_data, 64'h0123456789ABCDEF);

        // randomized traffic, busy, dout_ready and occasional resets
        auto_mode = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (rq[i].size() < 2 && $urandom_range(0, 7) == 0) push_rand(i);
            end
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                flush();
            end else begin
                rst = 1'b0;
            end
            step();
        end
        rst = 1'b0;
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
